game_turn_ctrl: RTL and testbench
=================================

Name: game_turn_ctrl

Overview:
- Parametrised successor to the two-player Connect4 game FSM.
- Sequences turns for 2..NUM_PLAYERS players and registers all outputs.
- Consumes a per-move result from the win/board checker, counts moves, and supports rematch without reset.
- Sits between the column-input/drop logic and the display/status logic.

Parameters:
NUM_PLAYERS, 2, number of players rotating turns (2..8)
BOARD_CELLS, 42, max moves before board is full (ROWS*COLS)
TURN_TIMEOUT, 1000000, clk cycles allowed per turn (used only with TURN_TIMER_EN)
PW, $clog2(NUM_PLAYERS) (min 1), player-id width (derived, localparam)
MW, $clog2(BOARD_CELLS+1), move-counter width (derived, localparam)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  pulse: begin game from IDLE, or rematch from END
move_valid  in  1  pulse: a player dropped a piece this cycle
move_player  in  PW  id of player issuing move_valid
invalid_move  in  1  column full / illegal drop, qualifies move_valid
win_detect  in  1  checker result for last accepted move, valid in EVAL
board_full  in  1  checker: no empty cell, valid in EVAL
current_state  out  2  IDLE=0, TURN=1, EVAL=2, END=3
current_player  out  PW  player whose turn it is
game_status  out  2  PLAYING=0, WIN=1, TIE=2, FORFEIT=3
winner  out  PW  winning player id, valid when game_status=WIN
move_accept  out  1  1-cycle pulse, move accepted
move_reject  out  1  1-cycle pulse, move ignored (wrong player or invalid)
board_clear  out  1  1-cycle pulse, external board must clear
move_count  out  MW  accepted moves this game, saturates at BOARD_CELLS
turn_timeout  out  1  1-cycle pulse, turn skipped by timer

Behaviour:
- Reset (reset=0, async): state=IDLE; current_player=0; game_status=PLAYING; winner=0; move_count=0; all pulses=0; timer=0.
- IDLE: start -> TURN next cycle; board_clear pulses that cycle; current_player=0; move_count=0.
- TURN: move_valid && move_player==current_player && !invalid_move -> move_accept=1, move_count+1, go to EVAL.
  - move_valid with wrong player or invalid_move -> move_reject=1; stay in TURN; no count change.
  - move_valid is sampled only in TURN; it is ignored silently in all other states.
- EVAL (exactly 1 cycle):
  - win_detect -> END, game_status=WIN, winner=current_player.
  - Else board_full or move_count==BOARD_CELLS -> END, TIE.
  - Else current_player advances to (current_player+1) mod NUM_PLAYERS (wraps NUM_PLAYERS-1 -> 0), back to TURN.
  - Win has priority over tie when the last cell completes a line.
- END: hold all outputs. start -> TURN with current_player = (winner+1) mod NUM_PLAYERS, or player 0 after TIE/FORFEIT. On that transition: board_clear pulses, move_count=0, game_status=PLAYING.
- start in TURN or EVAL is ignored. Reset mid-game always returns to IDLE.
- Latency: accepted move to next player's TURN = 2 clk; accepted move to END = 2 clk.
- move_count never exceeds BOARD_CELLS.

Optional Feature:
- Macro: GAME_TURN_TIMER_EN.
- With the macro:
  - A per-turn counter runs in TURN and clears on entering TURN.
  - On reaching TURN_TIMEOUT-1: turn_timeout pulses and current_player advances, with no move counted.
  - NUM_PLAYERS consecutive timeouts with no accepted move in between -> END, game_status=FORFEIT.
  - An accepted move clears the consecutive-timeout count.
  - A move arriving on the timeout cycle wins (it is accepted, no timeout).
- Without the macro: no counter logic; turn_timeout tied to 0; FORFEIT never produced.

Decomposition:
- Shared package game_pkg:
  - state encodings (IDLE/TURN/EVAL/END);
  - status encodings (PLAYING/WIN/TIE/FORFEIT);
  - default BOARD_CELLS=42.
- One natural sub-module: turn_timer (load/clear, terminal-count pulse), instantiated only under GAME_TURN_TIMER_EN.

Test Plan:
- NUM_PLAYERS=2: reset low, start -> board_clear pulse, state=TURN, current_player=0, move_count=0.
- Move by player 1 during player 0's turn -> move_reject=1, current_player stays 0. Then valid move by player 0 -> move_accept, EVAL, then current_player=1 after 2 clk, move_count=1.
- NUM_PLAYERS=3: 3 valid moves -> current_player sequence 0,1,2,0 (wrap).
- win_detect=1 and board_full=1 in the same EVAL cycle -> game_status=WIN, winner=current_player. Then start -> TURN, current_player=winner+1, move_count=0.
- invalid_move=1 with correct player -> reject, no count. 42 accepted moves with win_detect=0 -> game_status=TIE, move_count=42. Reset asserted mid-TURN -> outputs return to reset values immediately.
- With GAME_TURN_TIMER_EN, TURN_TIMEOUT=8, NUM_PLAYERS=2:
  - idle in TURN -> turn_timeout pulse after 8 clk;
  - two consecutive timeouts -> END with FORFEIT;
  - move arriving on the timeout cycle -> accepted, no turn_timeout pulse.

Source files
------------

// File: rtl/game_turn_ctrl_pkg.sv
// Shared encodings and defaults for the turn controller.
// Used by game_turn_ctrl and its optional turn_timer.
package game_pkg;

  // Controller state, visible on current_state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TURN = 2'd1,
    ST_EVAL = 2'd2,
    ST_END  = 2'd3
  } state_t;

  // Outcome of the current or last game, visible on game_status.
  typedef enum logic [1:0] {
    GS_PLAYING = 2'd0,
    GS_WIN     = 2'd1,
    GS_TIE     = 2'd2,
    GS_FORFEIT = 2'd3
  } status_t;

  // Classic 6x7 board.
  localparam int DEFAULT_BOARD_CELLS = 42;

  // Width needed to hold ids 0..n-1, never less than one bit.
  function automatic int id_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_turn_ctrl_turn_timer.sv
// Per-turn cycle counter. Counts while i_run is high, restarts when
// i_run drops, when i_clear is high, or after reaching its terminal count.
// o_tc is high on the last allowed cycle of a turn (count == TIMEOUT-1).
module turn_timer #(
  parameter  int TIMEOUT = 8,
  localparam int CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tc
);

  logic [CW-1:0] r_cnt;

  assign o_tc = i_run && (r_cnt == CW'(TIMEOUT - 1));

  // Count cycles spent in the current turn; any restart condition zeroes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!i_run || i_clear || o_tc) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_turn_ctrl.sv
// Turn sequencer for a 2..NUM_PLAYERS board game (Connect4 successor).
// All outputs are registered. Define GAME_TURN_TIMER_EN to add the
// per-turn timeout / forfeit logic; without it turn_timeout is tied low.
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter  int NUM_PLAYERS  = 2,
  parameter  int BOARD_CELLS  = DEFAULT_BOARD_CELLS,
  parameter  int TURN_TIMEOUT = 1000000,
  localparam int PW           = id_width(NUM_PLAYERS),
  localparam int MW           = $clog2(BOARD_CELLS + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          move_valid,
  input  logic [PW-1:0] move_player,
  input  logic          invalid_move,
  input  logic          win_detect,
  input  logic          board_full,
  output logic [1:0]    current_state,
  output logic [PW-1:0] current_player,
  output logic [1:0]    game_status,
  output logic [PW-1:0] winner,
  output logic          move_accept,
  output logic          move_reject,
  output logic          board_clear,
  output logic [MW-1:0] move_count,
  output logic          turn_timeout
);

  // Reject impossible configurations at elaboration.
  if (NUM_PLAYERS < 2 || NUM_PLAYERS > 8 || BOARD_CELLS < 1 || TURN_TIMEOUT < 2) begin : g_param_check
    $error("game_turn_ctrl: parameter out of range");
  end

  state_t        r_state,  w_state_next;
  status_t       r_status, w_status_next;
  logic [PW-1:0] r_player, w_player_next;
  logic [PW-1:0] r_winner, w_winner_next;
  logic [MW-1:0] r_count,  w_count_next;
  logic          r_accept, w_accept_next;
  logic          r_reject, w_reject_next;
  logic          r_clear,  w_clear_next;
  logic          r_timeout, w_timeout_next;

  logic          w_move_ok;
  logic [PW-1:0] w_player_inc;
  logic [PW-1:0] w_winner_inc;
  logic [MW-1:0] w_count_inc;

  // A move counts only from the player on turn and only if the drop was legal.
  assign w_move_ok    = move_valid && (move_player == r_player) && !invalid_move;
  assign w_player_inc = (r_player == PW'(NUM_PLAYERS - 1)) ? '0 : r_player + 1'b1;
  assign w_winner_inc = (r_winner == PW'(NUM_PLAYERS - 1)) ? '0 : r_winner + 1'b1;
  assign w_count_inc  = (r_count == MW'(BOARD_CELLS)) ? r_count : r_count + 1'b1;

`ifdef GAME_TURN_TIMER_EN
  logic [PW-1:0] r_to_cnt, w_to_cnt_next;
  logic          w_tc;

  turn_timer #(
    .TIMEOUT (TURN_TIMEOUT)
  ) u_turn_timer (
    .clk     (clk),
    .reset   (reset),
    .i_run   (r_state == ST_TURN),
    .i_clear (w_move_ok),
    .o_tc    (w_tc)
  );
`endif

  // Next-state and next-output decode; every target defaults to hold / idle.
  always_comb begin
    w_state_next   = r_state;
    w_status_next  = r_status;
    w_player_next  = r_player;
    w_winner_next  = r_winner;
    w_count_next   = r_count;
    w_accept_next  = 1'b0;
    w_reject_next  = 1'b0;
    w_clear_next   = 1'b0;
    w_timeout_next = 1'b0;
`ifdef GAME_TURN_TIMER_EN
    w_to_cnt_next  = r_to_cnt;
`endif
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next  = ST_TURN;
          w_status_next = GS_PLAYING;
          w_player_next = '0;
          w_winner_next = '0;
          w_count_next  = '0;
          w_clear_next  = 1'b1;
`ifdef GAME_TURN_TIMER_EN
          w_to_cnt_next = '0;
`endif
        end
      end
      ST_TURN: begin
        if (w_move_ok) begin
          // A legal move beats a timeout landing on the same cycle.
          w_state_next  = ST_EVAL;
          w_count_next  = w_count_inc;
          w_accept_next = 1'b1;
`ifdef GAME_TURN_TIMER_EN
          w_to_cnt_next = '0;
`endif
        end else begin
          if (move_valid) begin
            w_reject_next = 1'b1;
          end
`ifdef GAME_TURN_TIMER_EN
          if (w_tc) begin
            w_timeout_next = 1'b1;
            // Everybody timed out in a row: nobody is playing any more.
            if (r_to_cnt == PW'(NUM_PLAYERS - 1)) begin
              w_state_next  = ST_END;
              w_status_next = GS_FORFEIT;
            end else begin
              w_to_cnt_next = r_to_cnt + 1'b1;
              w_player_next = w_player_inc;
            end
          end
`endif
        end
      end
      ST_EVAL: begin
        // Win is checked first so a line completed by the last cell is a win.
        if (win_detect) begin
          w_state_next  = ST_END;
          w_status_next = GS_WIN;
          w_winner_next = r_player;
        end else if (board_full || (r_count == MW'(BOARD_CELLS))) begin
          w_state_next  = ST_END;
          w_status_next = GS_TIE;
        end else begin
          w_state_next  = ST_TURN;
          w_player_next = w_player_inc;
        end
      end
      ST_END: begin
        if (start) begin
          // Rematch: the loser-after-winner opens, otherwise player 0.
          w_state_next  = ST_TURN;
          w_player_next = (r_status == GS_WIN) ? w_winner_inc : '0;
          w_status_next = GS_PLAYING;
          w_winner_next = '0;
          w_count_next  = '0;
          w_clear_next  = 1'b1;
`ifdef GAME_TURN_TIMER_EN
          w_to_cnt_next = '0;
`endif
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_status  <= GS_PLAYING;
      r_player  <= '0;
      r_winner  <= '0;
      r_count   <= '0;
      r_accept  <= 1'b0;
      r_reject  <= 1'b0;
      r_clear   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_status  <= w_status_next;
      r_player  <= w_player_next;
      r_winner  <= w_winner_next;
      r_count   <= w_count_next;
      r_accept  <= w_accept_next;
      r_reject  <= w_reject_next;
      r_clear   <= w_clear_next;
      r_timeout <= w_timeout_next;
    end
  end

`ifdef GAME_TURN_TIMER_EN
  // Consecutive-timeout counter, cleared by any accepted move or new game.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_next;
    end
  end
`endif

  assign current_state  = r_state;
  assign game_status    = r_status;
  assign current_player = r_player;
  assign winner         = r_winner;
  assign move_count     = r_count;
  assign move_accept    = r_accept;
  assign move_reject    = r_reject;
  assign board_clear    = r_clear;
  assign turn_timeout   = r_timeout;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed self-checking bench for game_turn_ctrl.
// u_dut_a: 2 players, u_dut_b: 3 players; both 42 cells, timeout 8 cycles.
module tb_game_turn_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       mv;
  logic [1:0] mp;
  logic       inv;
  logic       win;
  logic       full;

  logic [1:0] a_state, a_status;
  logic [0:0] a_player, a_winner;
  logic       a_accept, a_reject, a_clear, a_timeout;
  logic [5:0] a_count;

  logic [1:0] b_state, b_status;
  logic [1:0] b_player, b_winner;
  logic       b_accept, b_reject, b_clear, b_timeout;
  logic [5:0] b_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  game_turn_ctrl #(.NUM_PLAYERS(2), .BOARD_CELLS(42), .TURN_TIMEOUT(8)) u_dut_a (
    .clk(clk), .reset(reset), .start(start), .move_valid(mv), .move_player(mp[0:0]),
    .invalid_move(inv), .win_detect(win), .board_full(full),
    .current_state(a_state), .current_player(a_player), .game_status(a_status),
    .winner(a_winner), .move_accept(a_accept), .move_reject(a_reject),
    .board_clear(a_clear), .move_count(a_count), .turn_timeout(a_timeout)
  );

  game_turn_ctrl #(.NUM_PLAYERS(3), .BOARD_CELLS(42), .TURN_TIMEOUT(8)) u_dut_b (
    .clk(clk), .reset(reset), .start(start), .move_valid(mv), .move_player(mp),
    .invalid_move(inv), .win_detect(win), .board_full(full),
    .current_state(b_state), .current_player(b_player), .game_status(b_status),
    .winner(b_winner), .move_accept(b_accept), .move_reject(b_reject),
    .board_clear(b_clear), .move_count(b_count), .turn_timeout(b_timeout)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; mv = 1'b0; mp = 2'd0; inv = 1'b0; win = 1'b0; full = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
  endtask

  task automatic begin_game();
    start = 1'b1;
    step();
    start = 1'b0;
    $display("start: a_state=%0d a_player=%0d b_state=%0d b_player=%0d", a_state, a_player, b_state, b_player);
  endtask

  task automatic move(input logic [1:0] p, input logic bad_drop);
    mv = 1'b1; mp = p; inv = bad_drop;
    step();
    mv = 1'b0; inv = 1'b0;
    $display("move p=%0d inv=%0d: a_acc=%0d a_rej=%0d a_cnt=%0d b_acc=%0d b_rej=%0d b_cnt=%0d",
             p, bad_drop, a_accept, a_reject, a_count, b_accept, b_reject, b_count);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; mv = 1'b0; mp = 2'd0; inv = 1'b0; win = 1'b0; full = 1'b0;
    step(); step();
    total++; if (a_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", a_state); end
    total++; if (a_player !== 1'b0) begin bad++; $display("FAIL reset_player got=%0d exp=0", a_player); end
    total++; if (a_status !== 2'd0) begin bad++; $display("FAIL reset_status got=%0d exp=0", a_status); end
    total++; if (a_winner !== 1'b0) begin bad++; $display("FAIL reset_winner got=%0d exp=0", a_winner); end
    total++; if (a_count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    total++; if ({a_accept, a_reject, a_clear, a_timeout} !== 4'b0000) begin bad++;
      $display("FAIL reset_pulses got=%b exp=0000", {a_accept, a_reject, a_clear, a_timeout}); end
    reset = 1'b1;
    step();
    total++; if (a_state !== 2'd0) begin bad++; $display("FAIL idle_hold got=%0d exp=0", a_state); end
  endtask

  task automatic test_start();
    begin_game();
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL start_state got=%0d exp=1", a_state); end
    total++; if (a_clear !== 1'b1) begin bad++; $display("FAIL start_clear got=%0d exp=1", a_clear); end
    total++; if (a_player !== 1'b0) begin bad++; $display("FAIL start_player got=%0d exp=0", a_player); end
    total++; if (a_count !== 6'd0) begin bad++; $display("FAIL start_count got=%0d exp=0", a_count); end
    step();
    total++; if (a_clear !== 1'b0) begin bad++; $display("FAIL clear_pulse_width got=%0d exp=0", a_clear); end
  endtask

  task automatic test_reject_then_accept();
    move(2'd1, 1'b0);
    total++; if (a_reject !== 1'b1) begin bad++; $display("FAIL wrong_player_reject got=%0d exp=1", a_reject); end
    total++; if (a_accept !== 1'b0) begin bad++; $display("FAIL wrong_player_accept got=%0d exp=0", a_accept); end
    total++; if (a_player !== 1'b0) begin bad++; $display("FAIL wrong_player_turn got=%0d exp=0", a_player); end
    total++; if (a_count !== 6'd0) begin bad++; $display("FAIL wrong_player_count got=%0d exp=0", a_count); end
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL wrong_player_state got=%0d exp=1", a_state); end
    move(2'd0, 1'b0);
    total++; if (a_accept !== 1'b1) begin bad++; $display("FAIL accept_pulse got=%0d exp=1", a_accept); end
    total++; if (a_state !== 2'd2) begin bad++; $display("FAIL accept_eval got=%0d exp=2", a_state); end
    total++; if (a_count !== 6'd1) begin bad++; $display("FAIL accept_count got=%0d exp=1", a_count); end
    step();
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL next_turn_state got=%0d exp=1", a_state); end
    total++; if (a_player !== 1'b1) begin bad++; $display("FAIL next_turn_player got=%0d exp=1", a_player); end
    total++; if (a_accept !== 1'b0) begin bad++; $display("FAIL accept_pulse_width got=%0d exp=0", a_accept); end
  endtask

  task automatic test_invalid();
    move(2'd1, 1'b1);
    total++; if (a_reject !== 1'b1) begin bad++; $display("FAIL invalid_reject got=%0d exp=1", a_reject); end
    total++; if (a_count !== 6'd1) begin bad++; $display("FAIL invalid_count got=%0d exp=1", a_count); end
    total++; if (a_player !== 1'b1) begin bad++; $display("FAIL invalid_player got=%0d exp=1", a_player); end
    step();
    total++; if (a_reject !== 1'b0) begin bad++; $display("FAIL reject_pulse_width got=%0d exp=0", a_reject); end
  endtask

  task automatic test_start_ignored();
    start = 1'b1; step(); start = 1'b0;
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL start_in_turn_state got=%0d exp=1", a_state); end
    total++; if (a_clear !== 1'b0) begin bad++; $display("FAIL start_in_turn_clear got=%0d exp=0", a_clear); end
    move(2'd1, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL start_in_eval_state got=%0d exp=1", a_state); end
    total++; if (a_player !== 1'b0) begin bad++; $display("FAIL start_in_eval_player got=%0d exp=0", a_player); end
    total++; if (a_clear !== 1'b0) begin bad++; $display("FAIL start_in_eval_clear got=%0d exp=0", a_clear); end
    total++; if (a_count !== 6'd2) begin bad++; $display("FAIL start_in_eval_count got=%0d exp=2", a_count); end
  endtask

  task automatic test_win_priority();
    do_reset();
    begin_game();
    move(2'd0, 1'b0);
    win = 1'b1; full = 1'b1;
    step();
    win = 1'b0; full = 1'b0;
    total++; if (a_state !== 2'd3) begin bad++; $display("FAIL win_state got=%0d exp=3", a_state); end
    total++; if (a_status !== 2'd1) begin bad++; $display("FAIL win_over_tie got=%0d exp=1", a_status); end
    total++; if (a_winner !== 1'b0) begin bad++; $display("FAIL win_winner got=%0d exp=0", a_winner); end
    move(2'd1, 1'b0);
    total++; if ({a_accept, a_reject} !== 2'b00) begin bad++; $display("FAIL move_in_end got=%b exp=00", {a_accept, a_reject}); end
    total++; if (a_state !== 2'd3) begin bad++; $display("FAIL end_hold got=%0d exp=3", a_state); end
    begin_game();
    total++; if (a_state !== 2'd1) begin bad++; $display("FAIL rematch_state got=%0d exp=1", a_state); end
    total++; if (a_player !== 1'b1) begin bad++; $display("FAIL rematch_player got=%0d exp=1", a_player); end
    total++; if (a_status !== 2'd0) begin bad++; $display("FAIL rematch_status got=%0d exp=0", a_status); end
    total++; if (a_clear !== 1'b1) begin bad++; $display("FAIL rematch_clear got=%0d exp=1", a_clear); end
  endtask

  task automatic test_tie42();
    do_reset();
    begin_game();
    for (int i = 0; i < 42; i++) begin
      move(2'(i % 2), 1'b0);
      total++; if (a_accept !== 1'b1 || a_count !== 6'(i + 1)) begin bad++;
        $display("FAIL tie_move%0d got=acc%0d/cnt%0d exp=acc1/cnt%0d", i, a_accept, a_count, i + 1); end
      step();
    end
    total++; if (a_state !== 2'd3) begin bad++; $display("FAIL tie_state got=%0d exp=3", a_state); end
    total++; if (a_status !== 2'd2) begin bad++; $display("FAIL tie_status got=%0d exp=2", a_status); end
    total++; if (a_count !== 6'd42) begin bad++; $display("FAIL tie_count got=%0d exp=42", a_count); end
    begin_game();
    total++; if (a_player !== 1'b0) begin bad++; $display("FAIL tie_rematch_player got=%0d exp=0", a_player); end
    total++; if (a_count !== 6'd0) begin bad++; $display("FAIL tie_rematch_count got=%0d exp=0", a_count); end
  endtask

  task automatic test_wrap3();
    logic [1:0] exp_p;
    do_reset();
    begin_game();
    move(2'd2, 1'b0);
    total++; if (b_reject !== 1'b1) begin bad++; $display("FAIL b_reject got=%0d exp=1", b_reject); end
    for (int i = 0; i < 5; i++) begin
      move(2'(i % 3), 1'b0);
      step();
      exp_p = 2'((i + 1) % 3);
      total++; if (b_player !== exp_p) begin bad++; $display("FAIL b_rotate%0d got=%0d exp=%0d", i, b_player, exp_p); end
    end
    move(2'd2, 1'b0);
    win = 1'b1; step(); win = 1'b0;
    total++; if (b_status !== 2'd1 || b_winner !== 2'd2) begin bad++;
      $display("FAIL b_win got=st%0d/w%0d exp=st1/w2", b_status, b_winner); end
    total++; if (b_count !== 6'd6) begin bad++; $display("FAIL b_count got=%0d exp=6", b_count); end
    total++; if (b_timeout !== 1'b0) begin bad++; $display("FAIL b_timeout got=%0d exp=0", b_timeout); end
    begin_game();
    total++; if (b_player !== 2'd0) begin bad++; $display("FAIL b_rematch_wrap got=%0d exp=0", b_player); end
    total++; if (b_clear !== 1'b1) begin bad++; $display("FAIL b_rematch_clear got=%0d exp=1", b_clear); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    begin_game();
    move(2'd0, 1'b0);
    step();
    #1 reset = 1'b0;
    #1;
    total++; if (a_state !== 2'd0) begin bad++; $display("FAIL async_state got=%0d exp=0", a_state); end
    total++; if (a_player !== 1'b0) begin bad++; $display("FAIL async_player got=%0d exp=0", a_player); end
    total++; if (a_count !== 6'd0) begin bad++; $display("FAIL async_count got=%0d exp=0", a_count); end
    step();
    reset = 1'b1;
    step();
  endtask

`ifdef GAME_TURN_TIMER_EN
  task automatic test_timer();
    do_reset();
    begin_game();
    for (int k = 1; k < 8; k++) begin
      step();
      total++; if (a_timeout !== 1'b0) begin bad++; $display("FAIL early_timeout%0d got=1 exp=0", k); end
    end
    step();
    total++; if (a_timeout !== 1'b1) begin bad++; $display("FAIL timeout1 got=%0d exp=1", a_timeout); end
    total++; if (a_player !== 1'b1 || a_state !== 2'd1) begin bad++;
      $display("FAIL timeout1_skip got=p%0d/s%0d exp=p1/s1", a_player, a_state); end
    total++; if (a_count !== 6'd0) begin bad++; $display("FAIL timeout1_count got=%0d exp=0", a_count); end
    for (int k = 9; k < 16; k++) step();
    step();
    total++; if (a_timeout !== 1'b1) begin bad++; $display("FAIL timeout2 got=%0d exp=1", a_timeout); end
    total++; if (a_state !== 2'd3 || a_status !== 2'd3) begin bad++;
      $display("FAIL forfeit got=s%0d/st%0d exp=s3/st3", a_state, a_status); end
    begin_game();
    total++; if (a_player !== 1'b0 || a_status !== 2'd0) begin bad++;
      $display("FAIL forfeit_rematch got=p%0d/st%0d exp=p0/st0", a_player, a_status); end
    for (int k = 1; k < 8; k++) step();
    move(2'd0, 1'b0);
    total++; if (a_accept !== 1'b1 || a_timeout !== 1'b0) begin bad++;
      $display("FAIL move_on_timeout got=acc%0d/to%0d exp=acc1/to0", a_accept, a_timeout); end
    step();
    total++; if (a_timeout !== 1'b0 || a_player !== 1'b1) begin bad++;
      $display("FAIL after_move_on_timeout got=to%0d/p%0d exp=to0/p1", a_timeout, a_player); end
  endtask
`else
  task automatic test_timer();
    do_reset();
    begin_game();
    for (int k = 0; k < 20; k++) begin
      step();
      total++; if (a_timeout !== 1'b0 || a_state !== 2'd1) begin bad++;
        $display("FAIL no_timer%0d got=to%0d/s%0d exp=to0/s1", k, a_timeout, a_state); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_start();
    test_reject_then_accept();
    test_invalid();
    test_start_ignored();
    test_win_priority();
    test_tie42();
    test_wrap3();
    test_reset_mid();
    test_timer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
